// File: rtl/fir_mac_seq_pkg.sv
// Shared types and helpers for the FIR MAC sequencer (package fir_pkg).
package fir_pkg;

  localparam int unsigned FIR_AW = 6;
  localparam int unsigned FIR_DW = 18;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    START,
    RUN,
    DONE
  } state_e;

  // Caller truncates the result to the address width, which gives the modulo wrap.
  function automatic logic [31:0] addr_sub(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

endpackage

// File: rtl/fir_mac_seq_if.sv
// Sequencer <-> MAC control/result bundle; names follow the sequencer's view.
interface fir_mac_seq_if
  import fir_pkg::*;
#(
  parameter int unsigned AW = FIR_AW,
  parameter int unsigned DW = FIR_DW
);

  logic          stf_o;
  logic [AW-1:0] n_o;
  logic [5:0]    s_o;
  logic [AW-1:0] i_i;
  logic          eof_i;
  logic [DW-1:0] y_i;

  modport master (output stf_o, n_o, s_o, input i_i, eof_i, y_i);
  modport slave  (input stf_o, n_o, s_o, output i_i, eof_i, y_i);

endinterface

// File: rtl/fir_mac_seq_addr_gen.sv
// Circular write pointer plus registered sample-read / coefficient addresses.
module fir_addr_gen
  import fir_pkg::*;
#(
  parameter int unsigned AW = FIR_AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  input  logic          adv_i,
  input  logic [AW-1:0] tap_i,
  output logic [AW-1:0] wr_ptr_o,
  output logic [AW-1:0] raddr_o,
  output logic [AW-1:0] coef_o
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] raddr_q, raddr_d;
  logic [AW-1:0] coef_q, coef_d;

  // Next-state: advance pointer after a result, track tap index while running.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    raddr_d  = raddr_q;
    coef_d   = coef_q;
    if (adv_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (run_i) begin
      raddr_d = AW'(addr_sub(32'(wr_ptr_q), 32'(tap_i)));
      coef_d  = tap_i;
    end
  end

  // Address registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      raddr_q  <= '0;
      coef_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      raddr_q  <= raddr_d;
      coef_q   <= coef_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign raddr_o  = raddr_q;
  assign coef_o   = coef_q;

endmodule

// File: rtl/fir_mac_seq.sv
// FIR sequencer: buffers samples, kicks the MAC, captures results.
// Optional overrun counter output enabled by FIR_OVR_CNT_EN.
module fir_mac_seq
  import fir_pkg::*;
#(
  parameter int unsigned AW = FIR_AW,
  parameter int unsigned DW = FIR_DW,
  parameter int unsigned CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          x_valid_i,
  input  logic [DW-1:0] x_i,
  input  logic [AW-1:0] ntaps_i,
  input  logic [5:0]    shift_i,
  input  logic          clr_i,
  fir_mac_seq_if.master mac,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [AW-1:0] mem_raddr_o,
  output logic [AW-1:0] coef_addr_o,
  output logic [DW-1:0] y_o,
  output logic          y_valid_o,
  output logic          busy_o,
  output logic          ovr_o
`ifdef FIR_OVR_CNT_EN
  ,
  output logic [CW-1:0] ovr_cnt_o
`endif
);

  state_e        state_q, state_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [AW-1:0] n_q, n_d;
  logic [5:0]    s_q, s_d;
  logic [DW-1:0] y_q, y_d;
  logic          ovr_q, ovr_d;
  logic          take, drop;

  assign take = (state_q == IDLE) && x_valid_i;
  assign drop = (state_q != IDLE) && x_valid_i;

  // Next-state and data-capture logic.
  always_comb begin
    state_d = state_q;
    wdata_d = wdata_q;
    n_d     = n_q;
    s_d     = s_q;
    y_d     = y_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE:  if (x_valid_i) state_d = WRITE;
      WRITE: state_d = START;
      START: state_d = RUN;
      RUN:   if (mac.eof_i) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take) begin
      wdata_d = x_i;
      n_d     = ntaps_i;
      s_d     = shift_i;
    end
    // Result is latched on the eof edge so y_o is valid alongside the DONE strobe.
    if ((state_q == RUN) && mac.eof_i) begin
      y_d = mac.y_i;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_i) begin
      ovr_d = 1'b0;
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wdata_q <= '0;
      n_q     <= '0;
      s_q     <= '0;
      y_q     <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdata_q <= wdata_d;
      n_q     <= n_d;
      s_q     <= s_d;
      y_q     <= y_d;
      ovr_q   <= ovr_d;
    end
  end

  fir_addr_gen #(
    .AW(AW)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .run_i    (state_q == RUN),
    .adv_i    (state_q == DONE),
    .tap_i    (mac.i_i),
    .wr_ptr_o (mem_waddr_o),
    .raddr_o  (mem_raddr_o),
    .coef_o   (coef_addr_o)
  );

  assign mac.stf_o   = (state_q == START);
  assign mac.n_o     = n_q;
  assign mac.s_o     = s_q;
  assign mem_we_o    = (state_q == WRITE);
  assign mem_wdata_o = wdata_q;
  assign y_o         = y_q;
  assign y_valid_o   = (state_q == DONE);
  assign busy_o      = (state_q != IDLE);
  assign ovr_o       = ovr_q;

`ifdef FIR_OVR_CNT_EN
  logic [CW-1:0] ovr_cnt_q, ovr_cnt_d;

  // Saturating drop counter; a drop coinciding with clear leaves a count of one.
  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    if (clr_i) begin
      ovr_cnt_d = drop ? CW'(1) : '0;
    end else if (drop && (ovr_cnt_q != '1)) begin
      ovr_cnt_d = ovr_cnt_q + CW'(1);
    end
  end

  // Drop counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovr_cnt_q <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
    end
  end

  assign ovr_cnt_o = ovr_cnt_q;
`else
  // Counter width only matters when the counter exists.
  logic [31:0] cw_unused;
  assign cw_unused = CW;
`endif

endmodule

// File: doc/fir_mac_seq.md
Name: fir_mac_seq

Overview:
Sequencer that turns the shared multiply-accumulate datapath into a streaming FIR filter.
- Accepts one input sample per request and writes it into a circular sample buffer.
- Pulses the MAC start strobe and steers sample-buffer and coefficient-memory read addresses from the MAC tap index.
- Captures the MAC result on end-of-filter and presents it with a one-cycle valid strobe.
- Sits between the sample source, the two memories (sample RAM, coefficient ROM) and the MAC.

Parameters:
- AW, 6, address width of sample buffer and coefficient memory; also the MAC tap-index width.
- DW, 18, sample and result data width.
- CW, 16, overrun counter width (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- x_valid_i  in  1  new-sample strobe, one cycle.
- x_i  in  DW  new sample.
- ntaps_i  in  AW  configured tap count minus one; sent to the MAC count input.
- shift_i  in  6  result scaling for the MAC adjust stage.
- clr_i  in  1  clears sticky error flags.
- stf_o  out  1  MAC start, one-cycle pulse.
- n_o  out  AW  latched ntaps_i sent to the MAC.
- s_o  out  6  latched shift_i sent to the MAC.
- i_i  in  AW  current MAC tap index.
- eof_i  in  1  MAC end-of-filter pulse.
- y_i  in  DW  MAC result.
- mem_we_o  out  1  sample RAM write enable.
- mem_waddr_o  out  AW  sample RAM write address.
- mem_wdata_o  out  DW  sample RAM write data.
- mem_raddr_o  out  AW  sample RAM read address.
- coef_addr_o  out  AW  coefficient ROM address.
- y_o  out  DW  filtered output, held until the next result.
- y_valid_o  out  1  one-cycle strobe when y_o updates.
- busy_o  out  1  high whenever the state is not IDLE.
- ovr_o  out  1  sticky overrun flag.

Behaviour:
- Reset values: all outputs 0; wr_ptr=0; state IDLE. Sample RAM contents are not cleared.
- FSM states: IDLE, WRITE, START, RUN, DONE.
- IDLE, x_valid_i=1 -> WRITE.
  - Same edge: register x_i into the write-data register.
  - Same edge: latch ntaps_i->n_o and shift_i->s_o. The shadow copies hold for the whole run, so config changes mid-run have no effect.
- WRITE:
  - mem_we_o=1, mem_waddr_o=wr_ptr, mem_wdata_o=latched sample.
  - Always -> START.
- START:
  - stf_o=1 for exactly one cycle.
  - Always -> RUN.
- RUN:
  - mem_raddr_o = (wr_ptr - i_i) mod 2^AW, registered (one cycle of latency from i_i).
  - coef_addr_o = i_i, registered with the same latency, so both reads stay aligned.
  - On eof_i=1 -> DONE.
- DONE:
  - y_o <= y_i; y_valid_o=1 for one cycle.
  - wr_ptr <= wr_ptr+1, wrapping 2^AW-1 -> 0.
  - Always -> IDLE.
- Throughput: one sample per (n+1)+4+MAC latency cycles. No sample is accepted in DONE, so back-to-back operation has one idle cycle.
- Overrun: any x_valid_i while busy_o=1 drops that sample and sets ovr_o.
  - This includes x_valid_i on the same cycle as eof_i.
  - ovr_o is cleared only by clr_i or rst_i. If clr_i and a new overrun coincide, set wins.
- eof_i outside RUN is ignored.
- Reset mid-run returns to IDLE immediately. y_o is not updated and no stf_o is issued.
- ntaps_i=0 is legal: single-tap filter, raddr=wr_ptr.

Optional Feature:
- Macro FIR_OVR_CNT_EN.
- Defined: adds output ovr_cnt_o [CW-1:0].
  - Increments once per dropped sample and saturates at 2^CW-1.
  - Cleared by clr_i or rst_i; if clr_i and a drop coincide, the result is 1.
- Undefined: the port and counter are absent; ovr_o behaviour is unchanged.

Decomposition:
- Shared package fir_pkg holds:
  - state enum (IDLE, WRITE, START, RUN, DONE);
  - default AW/DW constants;
  - function for modular address subtraction.
- One sub-module, fir_addr_gen: wr_ptr register with wrap, plus registered read/coefficient address generation. The FSM and output capture stay in the top.

Test Plan:
1. Reset, then one sample x=0x00100, ntaps_i=3, MAC model eof after 4 taps, y_i=0x00ABC.
   -> write at addr 0; stf_o exactly one pulse; raddr sequence 0,63,62,61; coef 0,1,2,3; y_o=0x00ABC with single y_valid_o; wr_ptr=1.
2. 64 consecutive samples.
   -> mem_waddr_o 0..63 then wraps to 0; 65th run raddr starts at 0 and the next tap reads 63.
3. x_valid_i pulsed during RUN and again coincident with eof_i.
   -> both dropped; ovr_o=1 sticky; with FIR_OVR_CNT_EN, ovr_cnt_o=2; clr_i returns both to 0.
4. ntaps_i changed from 3 to 7 during RUN.
   -> n_o stays 3 until the next accepted sample, then becomes 7.
5. rst_i asserted in RUN, tap 2.
   -> next cycle state IDLE, all outputs 0, no y_valid_o; the following sample is written at addr 0.
6. ntaps_i=0, sample at wr_ptr=5.
   -> single raddr=5, coef_addr 0, result captured on eof_i.
